decode_stage: RTL and testbench

Instruction-decode stage of the uDLX pipeline, directly upstream of the execute-stage ALU. Holds the register file, accepts instructions from fetch, extracts ALU opcode and function, reads or builds both ALU operands, and presents them to execute through one registered valid/ready stage. A per-register pending scoreboard stalls on read-after-write and write-after-write hazards until writeback retires the producer.

---
 rtl/decode_stage_if.sv | 36 +++
 rtl/decode_stage.sv | 142 ++++++++++++++
 tb/tb_decode_stage.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch/execute handshake bundle for decode_stage.
// slave: decode side; master: fetch + execute side.
interface decode_stage_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 3,
  parameter int ADDR_WIDTH   = 5,
  parameter int INSTR_WIDTH  = 32
);
  logic                    if_valid;
  logic [INSTR_WIDTH-1:0]  if_instruction;
  logic                    if_ready;
  logic                    ex_ready;
  logic                    id_valid;
  logic [DATA_WIDTH-1:0]   alu_data_in_a;
  logic [DATA_WIDTH-1:0]   alu_data_in_b;
  logic [OPCODE_WIDTH-1:0] alu_opcode;
  logic [OPCODE_WIDTH-1:0] alu_function;
  logic [ADDR_WIDTH-1:0]   id_write_address;
  logic                    id_write_enable;

  modport master (
    output if_valid, if_instruction, ex_ready,
    input  if_ready, id_valid,
    input  alu_data_in_a, alu_data_in_b,
    input  alu_opcode, alu_function,
    input  id_write_address, id_write_enable
  );

  modport slave (
    input  if_valid, if_instruction, ex_ready,
    output if_ready, id_valid,
    output alu_data_in_a, alu_data_in_b,
    output alu_opcode, alu_function,
    output id_write_address, id_write_enable
  );
endinterface

// File: rtl/decode_stage.sv
// uDLX decode: regfile, pending scoreboard, one output register.
// Ports: clk, rst, wb_* writeback, flush, bus (fetch in / execute out).
module decode_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 3,
  parameter int ADDR_WIDTH   = 5,
  parameter int INSTR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_write_enable,
  input  logic [ADDR_WIDTH-1:0] wb_write_address,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  input  logic                  flush,
  decode_stage_if.slave         bus
);
  localparam logic [5:0] TYPE_R_OPCODE = 6'h00;
  localparam logic [5:0] ADDI_OPCODE   = 6'h08;
  localparam logic [5:0] SUBI_OPCODE   = 6'h0A;
  localparam logic [5:0] ANDI_OPCODE   = 6'h0C;
  localparam logic [5:0] ORI_OPCODE    = 6'h0D;
  localparam int         NREG          = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]   rf_q [NREG];
  logic [NREG-1:0]         pend_q, pend_d;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [OPCODE_WIDTH-1:0] op_q, fn_q;
  logic [ADDR_WIDTH-1:0]   wa_q;
  logic                    we_q;

  logic [5:0]              opc;
  logic [ADDR_WIDTH-1:0]   rs1, rs2, rd, dest;
  logic [15:0]             imm;
  logic                    is_r, is_i, we;
  logic [NREG-1:0]         wb_hit, eff_pend;
  logic [DATA_WIDTH-1:0]   a_d, rs2_val, b_d;
  logic                    hazard, drain, ready, accept;

  assign opc = bus.if_instruction[31:26];
  assign rs1 = bus.if_instruction[21 +: ADDR_WIDTH];
  assign rs2 = bus.if_instruction[16 +: ADDR_WIDTH];
  assign rd  = bus.if_instruction[11 +: ADDR_WIDTH];
  assign imm = bus.if_instruction[15:0];

  always_comb begin
    is_r = 1'b0;
    is_i = 1'b0;
    unique case (1'b1)
      (opc == TYPE_R_OPCODE): is_r = 1'b1;
      (opc == ADDI_OPCODE),
      (opc == SUBI_OPCODE),
      (opc == ANDI_OPCODE),
      (opc == ORI_OPCODE):    is_i = 1'b1;
      default:                ;
    endcase
  end

  assign we   = is_r | is_i;
  assign dest = is_i ? rs2 : rd;

  // A writeback this cycle both bypasses reads and retires pending.
  assign wb_hit   = wb_write_enable ?
                    (NREG'(1) << wb_write_address) : '0;
  assign eff_pend = pend_q & ~wb_hit;

  always_comb begin
    a_d     = '0;
    rs2_val = '0;
    if (rs1 != '0)
      a_d = wb_hit[rs1] ? wb_write_data : rf_q[rs1];
    if (rs2 != '0)
      rs2_val = wb_hit[rs2] ? wb_write_data : rf_q[rs2];
    b_d = is_r ? rs2_val :
          {{(DATA_WIDTH-16){imm[15]}}, imm};
  end

  assign hazard = bus.if_valid &
                  (eff_pend[rs1] |
                   (is_r & eff_pend[rs2]) |
                   (we & eff_pend[dest]));
  assign drain  = ~valid_q | bus.ex_ready;
  assign ready  = drain & ~hazard & ~flush;
  assign accept = bus.if_valid & ready;

  // Set is applied after clears so it wins on the same address.
  always_comb begin
    pend_d = pend_q & ~wb_hit;
    if (flush && valid_q && we_q)
      pend_d[wa_q] = 1'b0;
    if (accept && we)
      pend_d[dest] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      fn_q    <= '0;
      wa_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        a_q     <= a_d;
        b_q     <= b_d;
        op_q    <= opc[OPCODE_WIDTH-1:0];
        fn_q    <= bus.if_instruction[OPCODE_WIDTH-1:0];
        wa_q    <= dest;
        we_q    <= we;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else if (wb_write_enable &&
                 wb_write_address != '0) begin
      rf_q[wb_write_address] <= wb_write_data;
    end
  end

  assign bus.if_ready         = ready;
  assign bus.id_valid         = valid_q;
  assign bus.alu_data_in_a    = a_q;
  assign bus.alu_data_in_b    = b_q;
  assign bus.alu_opcode       = op_q;
  assign bus.alu_function     = fn_q;
  assign bus.id_write_address = wa_q;
  assign bus.id_write_enable  = we_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed plan then random traffic.
// Reference model: register array, pending flags, output slot.
module tb_decode_stage;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SUBI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_NOP  = 6'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage_if #(
    .DATA_WIDTH(32), .OPCODE_WIDTH(3),
    .ADDR_WIDTH(5), .INSTR_WIDTH(32)
  ) bus ();

  decode_stage #(
    .DATA_WIDTH(32), .OPCODE_WIDTH(3),
    .ADDR_WIDTH(5), .INSTR_WIDTH(32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_write_enable  (wb_we),
    .wb_write_address (wb_wa),
    .wb_write_data    (wb_wd),
    .flush            (flush),
    .bus              (bus)
  );

  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_v, m_we;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op, m_fn;
  logic [4:0]  m_wa;

  function automatic logic [31:0] rtype(
    input logic [4:0] d, input logic [4:0] s1,
    input logic [4:0] s2, input logic [2:0] fn);
    return {OP_R, s1, s2, d, 8'd0, fn};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] d,
    input logic [4:0] s1, input logic [15:0] im);
    return {op, s1, d, im};
  endfunction

  function automatic bit is_imm(input logic [5:0] o);
    return o inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI};
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_we && wb_wa == r) return wb_wd;
    return m_rf[r];
  endfunction

  function automatic bit busy(input logic [4:0] r);
    if (r == 0) return 1'b0;
    return m_pend[r] && !(wb_we && wb_wa == r);
  endfunction

  function automatic bit m_ready();
    logic [31:0] ins;
    bit          r, w, hz;
    logic [4:0]  d;
    ins = bus.if_instruction;
    r   = (ins[31:26] == OP_R);
    w   = r || is_imm(ins[31:26]);
    d   = r ? ins[15:11] : ins[20:16];
    hz  = bus.if_valid &&
          (busy(ins[25:21]) || (r && busy(ins[20:16])) ||
           (w && busy(d)));
    return (!m_v || bus.ex_ready) && !hz && !flush;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_v = 0; m_we = 0; m_a = 0; m_b = 0;
    m_op = 0; m_fn = 0; m_wa = 0;
  endtask

  task automatic model_update();
    logic [31:0] ins;
    bit          r, w, acc;
    logic [4:0]  d;
    bit          np [32];
    if (rst) begin
      model_reset();
      return;
    end
    ins = bus.if_instruction;
    r   = (ins[31:26] == OP_R);
    w   = r || is_imm(ins[31:26]);
    d   = r ? ins[15:11] : ins[20:16];
    acc = bus.if_valid && m_ready();
    np  = m_pend;
    if (wb_we) np[wb_wa] = 1'b0;
    if (flush && m_v && m_we) np[m_wa] = 1'b0;
    if (acc && w && d != 0) np[d] = 1'b1;
    if (flush) begin
      m_v = 1'b0;
    end else if (acc) begin
      m_v  = 1'b1;
      m_a  = rd_reg(ins[25:21]);
      m_b  = r ? rd_reg(ins[20:16])
               : 32'($signed(ins[15:0]));
      m_op = ins[28:26];
      m_fn = ins[2:0];
      m_wa = d;
      m_we = w;
    end else if (!m_v || bus.ex_ready) begin
      m_v = 1'b0;
    end
    if (wb_we && wb_wa != 0) m_rf[wb_wa] = wb_wd;
    m_pend = np;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("id_valid", {31'd0, bus.id_valid}, {31'd0, m_v});
    chk("id_we", {31'd0, bus.id_write_enable},
        {31'd0, m_we});
    chk("alu_b", bus.alu_data_in_b, m_b);
    chk("alu_op", {29'd0, bus.alu_opcode}, {29'd0, m_op});
    chk("alu_fn", {29'd0, bus.alu_function}, {29'd0, m_fn});
    if (m_we) begin
      chk("alu_a", bus.alu_data_in_a, m_a);
      chk("id_wa", {27'd0, bus.id_write_address},
          {27'd0, m_wa});
    end
  endtask

  task automatic step(input int exp_rdy = -1);
    #1;
    chk("if_ready", {31'd0, bus.if_ready},
        {31'd0, m_ready()});
    if (exp_rdy >= 0)
      chk("if_ready_dir", {31'd0, bus.if_ready},
          32'(exp_rdy));
    @(posedge clk);
    model_update();
    #1;
    check_outs();
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{OP_R, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_NOP};
    model_reset();
    rst = 1; flush = 0;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    bus.if_valid = 0;
    bus.if_instruction = 0;
    bus.ex_ready = 1;
    @(posedge clk);
    #1;
    rst = 0;
    check_outs();
    chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_a", bus.alu_data_in_a, 32'd0);
    #1;
    chk("rst_ready", {31'd0, bus.if_ready}, 32'd1);

    wb_we = 1; wb_wa = 3; wb_wd = 32'h5;
    step(1);
    wb_we = 0;

    bus.if_valid = 1;
    bus.if_instruction = rtype(5'd1, 5'd3, 5'd3, 3'd1);
    step(1);
    chk("add_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("add_a", bus.alu_data_in_a, 32'd5);
    chk("add_b", bus.alu_data_in_b, 32'd5);
    chk("add_wa", {27'd0, bus.id_write_address}, 32'd1);
    chk("add_we", {31'd0, bus.id_write_enable}, 32'd1);
    chk("add_fn", {29'd0, bus.alu_function}, 32'd1);

    bus.if_instruction = itype(OP_ADDI, 5'd2, 5'd0, 16'hFFFE);
    step(1);
    chk("addi_a", bus.alu_data_in_a, 32'd0);
    chk("addi_b", bus.alu_data_in_b, 32'hFFFF_FFFE);
    chk("addi_wa", {27'd0, bus.id_write_address}, 32'd2);

    bus.if_valid = 0;
    wb_we = 1; wb_wa = 1; wb_wd = 32'h100;
    step();
    wb_wa = 2; wb_wd = 32'h200;
    step();
    wb_we = 0;

    bus.if_valid = 1;
    bus.if_instruction = rtype(5'd4, 5'd3, 5'd3, 3'd0);
    step(1);
    bus.if_instruction = rtype(5'd5, 5'd4, 5'd0, 3'd2);
    step(0);
    step(0);
    wb_we = 1; wb_wa = 4; wb_wd = 32'h44;
    step(1);
    wb_we = 0;
    chk("raw_a", bus.alu_data_in_a, 32'h44);
    chk("raw_wa", {27'd0, bus.id_write_address}, 32'd5);

    bus.if_valid = 0;
    step();
    bus.ex_ready = 0;
    bus.if_valid = 1;
    bus.if_instruction = itype(OP_ADDI, 5'd6, 5'd3, 16'd7);
    step(1);
    bus.if_instruction = itype(OP_ADDI, 5'd8, 5'd3, 16'd1);
    step(0);
    chk("hold_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("hold_b", bus.alu_data_in_b, 32'd7);
    step(0);
    chk("hold_a", bus.alu_data_in_a, 32'd5);
    chk("hold_wa", {27'd0, bus.id_write_address}, 32'd6);
    bus.ex_ready = 1;
    step(1);
    chk("rel_wa", {27'd0, bus.id_write_address}, 32'd8);
    for (int i = 9; i <= 12; i++) begin
      bus.if_instruction = itype(OP_ADDI, 5'(i), 5'd3, 16'(i));
      step(1);
      chk("stream_wa", {27'd0, bus.id_write_address},
          32'(i));
      chk("stream_b", bus.alu_data_in_b, 32'(i));
    end

    bus.if_instruction = itype(OP_ADDI, 5'd7, 5'd0, 16'd3);
    step(1);
    flush = 1;
    bus.if_instruction = rtype(5'd13, 5'd7, 5'd0, 3'd0);
    step(0);
    chk("flush_valid", {31'd0, bus.id_valid}, 32'd0);
    flush = 0;
    step(1);
    chk("post_flush_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("post_flush_wa", {27'd0, bus.id_write_address},
        32'd13);

    bus.if_valid = 0;
    wb_we = 1; wb_wa = 0; wb_wd = 32'hDEAD_BEEF;
    step();
    wb_we = 0;
    bus.if_valid = 1;
    bus.if_instruction = rtype(5'd14, 5'd0, 5'd0, 3'd0);
    step(1);
    chk("r0_a", bus.alu_data_in_a, 32'd0);
    chk("r0_b", bus.alu_data_in_b, 32'd0);
    wb_we = 1;
    bus.if_instruction = rtype(5'd15, 5'd0, 5'd0, 3'd0);
    step(1);
    chk("r0_byp_a", bus.alu_data_in_a, 32'd0);
    wb_we = 0;
    bus.if_instruction = itype(OP_ADDI, 5'd0, 5'd0, 16'd5);
    step(1);
    step(1);
    bus.if_valid = 0;
    step();

    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(99) == 0);
      flush        = ($urandom_range(15) == 0);
      bus.ex_ready = ($urandom_range(3) != 0);
      wb_we        = $urandom_range(1) == 1;
      wb_wa        = 5'($urandom_range(15));
      wb_wd        = $urandom;
      bus.if_valid = ($urandom_range(3) != 0);
      bus.if_instruction = {ops[$urandom_range(5)],
                            5'($urandom_range(15)),
                            5'($urandom_range(15)),
                            16'($urandom)};
      step();
    end

    rst = 0; flush = 0; wb_we = 0; bus.if_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
